// File: rtl/dstb_pkg.sv
// Shared definitions for the CPU clock speed controller: speed-state encoding
// and default timing parameters.
package dstb_pkg;

   typedef enum logic [1:0] {
      SLOW    = 2'd0,
      GO_FAST = 2'd1,
      FAST    = 2'd2,
      GO_SLOW = 2'd3
   } speed_state_t;

   localparam int unsigned HOLD_CYCLES_DEF = 8;
   localparam int unsigned ACK_TIMEOUT_DEF = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle-high strobes come out of reset inactive.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/speed_ctrl.sv
// CPU clock speed controller: drives a glitch-free clock-mux select between the
// slow chipset clock and the fast clock, dropping to slow for slow-zone accesses.
module speed_ctrl
   import dstb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic turbo_en,
   input  logic as_n,
   input  logic slow_zone,
   input  logic fast_ack,
   output logic select,
   output logic fast,
   output logic switching,
   output logic timeout_err
);

   localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam int unsigned TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   logic as_n_s, slow_zone_s, turbo_en_s, fast_ack_s;
   logic slow_req, want_slow;
   logic timed_out;

   speed_state_t state, state_nxt;
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] timer;

   sync2 #(.RST_VAL(1'b1)) u_sync_as_n      (.clk(clk), .rst(rst), .d(as_n),      .q(as_n_s));
   sync2 #(.RST_VAL(1'b0)) u_sync_slow_zone (.clk(clk), .rst(rst), .d(slow_zone), .q(slow_zone_s));
   sync2 #(.RST_VAL(1'b0)) u_sync_turbo_en  (.clk(clk), .rst(rst), .d(turbo_en),  .q(turbo_en_s));
   sync2 #(.RST_VAL(1'b0)) u_sync_fast_ack  (.clk(clk), .rst(rst), .d(fast_ack),  .q(fast_ack_s));

   assign slow_req  = ~as_n_s & slow_zone_s;
   assign want_slow = slow_req | ~turbo_en_s;

   // Abort and ack are examined before the timer, so an ack on the final cycle still wins.
   always_comb begin
      state_nxt = state;
      timed_out = 1'b0;
      unique case (state)
         SLOW: begin
            if (!want_slow && hold_cnt == '0)
               state_nxt = GO_FAST;
         end
         GO_FAST: begin
            if (want_slow)
               state_nxt = GO_SLOW;
            else if (fast_ack_s)
               state_nxt = FAST;
            else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               state_nxt = SLOW;
               timed_out = 1'b1;
            end
         end
         FAST: begin
            if (want_slow)
               state_nxt = GO_SLOW;
         end
         GO_SLOW: begin
            if (!fast_ack_s)
               state_nxt = SLOW;
            else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               state_nxt = SLOW;
               timed_out = 1'b1;
            end
         end
         default: state_nxt = SLOW;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SLOW;
         hold_cnt    <= HW'(HOLD_CYCLES);
         timer       <= '0;
         select      <= 1'b0;
         fast        <= 1'b0;
         switching   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;

         if (want_slow || state != SLOW)
            hold_cnt <= HW'(HOLD_CYCLES);
         else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;

         if (state_nxt != state)
            timer <= '0;
         else if (state == GO_FAST || state == GO_SLOW)
            timer <= timer + 1'b1;

         // Outputs are registered from the next state so they line up with state.
         select      <= (state_nxt == GO_FAST) || (state_nxt == FAST);
         fast        <= (state_nxt == FAST);
         switching   <= (state_nxt == GO_FAST) || (state_nxt == GO_SLOW);
         timeout_err <= timeout_err | timed_out;
      end
   end

endmodule

// File: tb/tb_speed_ctrl.sv
// Directed self-checking bench for speed_ctrl with default parameters
// (HOLD_CYCLES = 8, ACK_TIMEOUT = 16).
module tb_speed_ctrl;

   logic clk = 1'b0;
   logic rst, turbo_en, as_n, slow_zone, fast_ack;
   logic select, fast, switching, timeout_err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   speed_ctrl #(.HOLD_CYCLES(8), .ACK_TIMEOUT(16)) dut (
      .clk(clk),
      .rst(rst),
      .turbo_en(turbo_en),
      .as_n(as_n),
      .slow_zone(slow_zone),
      .fast_ack(fast_ack),
      .select(select),
      .fast(fast),
      .switching(switching),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic s, input logic f,
                          input logic sw, input logic e);
      chk({tag, ".select"},      select,      s);
      chk({tag, ".fast"},        fast,        f);
      chk({tag, ".switching"},   switching,   sw);
      chk({tag, ".timeout_err"}, timeout_err, e);
   endtask

   initial begin
      rst = 1'b1; turbo_en = 1'b0; as_n = 1'b1; slow_zone = 1'b0; fast_ack = 1'b0;
      repeat (3) tick();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);

      // Power-up to fast: select rises on edge 11 after release, fast 3 edges after ack.
      turbo_en = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("up.select_e10", select, 1'b0);
      tick();
      chk_all("up.go_fast", 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      fast_ack = 1'b1;
      repeat (2) tick();
      chk("up.fast_e16", fast, 1'b0);
      tick();
      chk_all("up.fast", 1'b1, 1'b1, 1'b0, 1'b0);

      // Fast-zone access leaves the speed alone.
      as_n = 1'b0; slow_zone = 1'b0;
      repeat (5) tick();
      chk_all("fastzone", 1'b1, 1'b1, 1'b0, 1'b0);
      as_n = 1'b1;

      // Slow-zone access: select drops on the 3rd edge, hold of 8 cycles, then back up.
      as_n = 1'b0; slow_zone = 1'b1;
      repeat (2) tick();
      chk("slow.select_e2", select, 1'b1);
      tick();
      chk_all("slow.go_slow", 1'b0, 1'b0, 1'b1, 1'b0);
      fast_ack = 1'b0; as_n = 1'b1; slow_zone = 1'b0;
      repeat (3) tick();
      chk_all("slow.in_slow", 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (8) tick();
      chk("slow.hold_end", select, 1'b0);
      tick();
      chk("slow.reup", select, 1'b1);
      fast_ack = 1'b1;
      repeat (3) tick();
      chk("slow.refast", fast, 1'b1);

      // One-cycle reset while FAST with ack still high.
      rst = 1'b1;
      tick();
      chk_all("rst_in_fast", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; fast_ack = 1'b0;

      // Slow access arriving during GO_FAST aborts to GO_SLOW.
      repeat (11) tick();
      chk_all("abort.go_fast", 1'b1, 1'b0, 1'b1, 1'b0);
      as_n = 1'b0; slow_zone = 1'b1;
      repeat (2) tick();
      chk("abort.select_e2", select, 1'b1);
      tick();
      chk_all("abort.go_slow", 1'b0, 1'b0, 1'b1, 1'b0);
      as_n = 1'b1; slow_zone = 1'b0;
      tick();
      chk_all("abort.slow", 1'b0, 1'b0, 1'b0, 1'b0);

      // Ack seen on the last permitted cycle of GO_FAST is honoured.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (11) tick();
      repeat (13) tick();
      fast_ack = 1'b1;
      repeat (2) tick();
      chk_all("lastack.pending", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("lastack.fast", 1'b1, 1'b1, 1'b0, 1'b0);

      // No ack at all: 16 cycles in GO_FAST, then timeout, sticky until reset.
      rst = 1'b1; fast_ack = 1'b0;
      tick();
      rst = 1'b0;
      repeat (11) tick();
      repeat (15) tick();
      chk_all("tmo.last", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_all("tmo.fire", 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (30) tick();
      chk("tmo.sticky", timeout_err, 1'b1);
      rst = 1'b1;
      tick();
      chk_all("tmo.cleared", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/speed_ctrl.md
SPEED_CTRL -- requirements
Module: speed_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8: minimum clk cycles spent slow after the last slow-zone access before returning fast.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: clk cycles allowed for mux acknowledgement before abandoning a switch.
REQ-003 SHALL have port clk  in  1: single free-running clock (fast oscillator); all state on rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port turbo_en  in  1: user/register request for fast mode; asynchronous.
REQ-006 SHALL have port as_n  in  1: CPU address strobe, active low; asynchronous.
REQ-007 SHALL have port slow_zone  in  1: address decode; high = current cycle targets ST chipset/slow memory; asynchronous; qualified by as_n low.
REQ-008 SHALL have port fast_ack  in  1: clock-mux feedback; high = output sourced from fast clock, low = from slow clock; asynchronous.
REQ-009 SHALL have port select  out  1: clock-mux select; low = slow clock (clk0), high = fast clock (clk1).
REQ-010 SHALL have port fast  out  1: high only in state FAST.
REQ-011 SHALL have port switching  out  1: high in GO_FAST or GO_SLOW.
REQ-012 SHALL have port timeout_err  out  1: sticky, set on any acknowledgement timeout.

Function
REQ-013 SHALL pass as_n, slow_zone, turbo_en, fast_ack through two-flop synchronisers (suffix _s) before any use.
REQ-014 SHALL define slow_req = ~as_n_s & slow_zone_s; want_slow = slow_req | ~turbo_en_s.
REQ-015 SHALL implement FSM states SLOW, GO_FAST, FAST, GO_SLOW; select = 1 in GO_FAST and FAST, 0 otherwise; all outputs registered.
REQ-016 SHALL keep hold_cnt (width clog2(HOLD_CYCLES+1)): reload to HOLD_CYCLES on any cycle with want_slow or any state other than SLOW; otherwise decrement in SLOW, saturating at 0.
REQ-017 SLOW -> GO_FAST SHALL occur when ~want_slow and hold_cnt == 0.
REQ-018 GO_FAST -> FAST SHALL occur when fast_ack_s = 1; GO_FAST -> GO_SLOW when want_slow (abort, priority over ack).
REQ-019 FAST -> GO_SLOW SHALL occur when want_slow; select therefore falls on the 3rd rising clk edge after as_n falls with slow_zone high (2 sync + 1 register).
REQ-020 GO_SLOW -> SLOW SHALL occur when fast_ack_s = 0.
REQ-021 SHALL keep ack timer, cleared on entry to GO_FAST/GO_SLOW, incrementing each cycle therein; when it reaches ACK_TIMEOUT-1 without the required ack, next state = SLOW and timeout_err sets.
REQ-022 Timeout in GO_FAST SHALL take priority over simultaneous ack arrival on that same cycle only if ack is absent; ack present on the final cycle SHALL be honoured.
REQ-023 timeout_err SHALL clear only on rst.
REQ-024 turbo_en toggling mid-switch SHALL be handled solely via want_slow; no other path.

Reset
REQ-025 On rst: state SLOW, select 0, fast 0, switching 0, timeout_err 0, hold_cnt = HOLD_CYCLES, timer 0.
REQ-026 On rst: as_n sync flops 1, slow_zone/turbo_en/fast_ack sync flops 0.
REQ-027 Reset asserted mid-switch SHALL force select 0 on the next edge regardless of fast_ack.

Structure
REQ-028 Shared package dstb_pkg SHALL hold the speed-state enum and HOLD_CYCLES/ACK_TIMEOUT defaults.
REQ-029 SHALL instantiate sub-module sync2 (two-flop synchroniser, reset value parameter) once per asynchronous input.

Verification
REQ-030 Reset, turbo_en=1, as_n=1, fast_ack follows select after 3 cycles -> select rises 2+1+8 cycles after reset release, fast=1 3 sync cycles later.
REQ-031 In FAST, as_n=0 with slow_zone=1 -> select=0 on 3rd edge; fast_ack low -> SLOW; as_n=1 -> select stays 0 for exactly 8 cycles of ~want_slow, then rises.
REQ-032 In FAST, as_n=0 with slow_zone=0 -> select stays 1, no state change.
REQ-033 turbo_en=1, fast_ack tied 0 -> GO_FAST for 16 cycles, then select=0, timeout_err=1, remains set until rst.
REQ-034 In GO_FAST, slow access arrives before ack -> GO_SLOW, select=0 next edge, timeout_err=0.
REQ-035 rst pulsed one cycle while in FAST -> select=0 next edge, all outputs at reset values.
